router_fifo: RTL and testbench

- Per-port output buffer of the 1x3 router, directly downstream of the synchronizer.
- Three instances, one per destination port: write_enb[n], soft_reset_n and read_enb_n come from the synchronizer and the output side.
- full and empty go back to the synchronizer, which derives fifo_full, vld_out_n and the 30-cycle soft-reset timeout from them.
- Stores header, payload and parity bytes, tags each header word, and tracks packet length on the read side.

---
 rtl/router_pkg.sv | 22 ++
 rtl/router_fifo_mem.sv | 35 +++
 rtl/router_fifo.sv | 78 +++++++
 tb/tb_router_fifo.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: byte width, FIFO depth, header field
// positions and the read-side packet counter type.
package router_pkg;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 16;

  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = 1;
  localparam int LEN_LSB  = 2;
  localparam int LEN_MSB  = 7;

  localparam int PKT_CNT_W = 7;

  typedef logic [PKT_CNT_W-1:0] pkt_cnt_t;

  // Bytes still to come after a header: payload length plus the parity byte.
  function automatic pkt_cnt_t hdr_pkt_len(input logic [DATA_W-1:0] hdr);
    return pkt_cnt_t'(hdr[LEN_MSB:LEN_LSB]) + pkt_cnt_t'(1);
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// 1-write/1-read register file for the router output FIFO. The data column
// has no reset; only the header-flag column is cleared on reset or flush.
module router_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clear,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W:0]   wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W:0]   rdata
);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  hdr_q;

  always_ff @(posedge clock) begin
    if (we)
      data_q[waddr] <= wdata[DATA_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (!resetn || clear)
      hdr_q <= '0;
    else if (we)
      hdr_q[waddr] <= wdata[DATA_W];
  end

  assign rdata = {hdr_q[raddr], data_q[raddr]};

endmodule

// File: rtl/router_fifo.sv
// Per-port output FIFO of the 1x3 router: header-tagged storage, full/empty
// flags for the synchronizer, and packet-length tracking on the read side.
module router_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] data_out
);

  import router_pkg::*;

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int AW    = PTR_W - 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  pkt_cnt_t         pkt_cnt;
  logic             wr_acc;
  logic             rd_acc;
  logic             mem_we;
  logic [DATA_W:0]  rd_word;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign wr_acc = write_enb && !full;
  assign rd_acc = read_enb && !empty;
  // A flush cycle must not land a byte in the array either.
  assign mem_we = wr_acc && resetn && !soft_reset;

  router_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clock  (clock),
    .resetn (resetn),
    .clear  (soft_reset),
    .we     (mem_we),
    .waddr  (wr_ptr[AW-1:0]),
    .wdata  ({lfd_state, data_in}),
    .raddr  (rd_ptr[AW-1:0]),
    .rdata  (rd_word)
  );

  always_ff @(posedge clock) begin
    if (!resetn || soft_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      data_out <= '0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        data_out <= rd_word[DATA_W-1:0];
        // A new header always reloads, even if the previous packet was cut short.
        if (rd_word[DATA_W])
          pkt_cnt <= hdr_pkt_len(rd_word[DATA_W-1:0]);
        else if (pkt_cnt != '0)
          pkt_cnt <= pkt_cnt - PKT_CNT_W'(1);
      end else if (pkt_cnt == '0) begin
        data_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Scoreboard bench for router_fifo: a queue-based reference model predicts
// flags, read data and idle output; a separate monitor checks every read.
module tb_router_fifo;

  logic       clock;
  logic       resetn;
  logic       soft_reset;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic       full;
  logic       empty;
  logic [7:0] data_out;

  int total = 0;
  int bad   = 0;

  logic [8:0] mq[$];
  logic [7:0] exp_q[$];
  int         m_pkt  = 0;
  logic [7:0] m_dout = 8'h00;

  router_fifo dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .full       (full),
    .empty      (empty),
    .data_out   (data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check pre-edge flags, advance the model.
  task automatic step(input logic we, input logic re, input logic lfd,
                      input logic [7:0] din, input logic sr);
    logic [8:0] w;
    bit rd_ok;
    bit wr_ok;
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = din;
    soft_reset = sr;
    check("full", full, 32'(mq.size() == 16));
    check("empty", empty, 32'(mq.size() == 0));
    rd_ok = 0;
    if (sr) begin
      mq.delete();
      m_pkt  = 0;
      m_dout = 8'h00;
    end else begin
      rd_ok = re && (mq.size() != 0);
      wr_ok = we && (mq.size() != 16);
      if (rd_ok) begin
        w = mq.pop_front();
        exp_q.push_back(w[7:0]);
        if (w[8])
          m_pkt = int'(w[7:2]) + 1;
        else if (m_pkt != 0)
          m_pkt--;
        m_dout = w[7:0];
      end else if (m_pkt == 0) begin
        m_dout = 8'h00;
      end
      if (wr_ok)
        mq.push_back({lfd, din});
    end
    @(posedge clock);
    #1;
    if (!rd_ok)
      check("dout_idle", data_out, m_dout);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wr(input logic lfd, input logic [7:0] din);
    step(1'b1, 1'b0, lfd, din, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  // Monitor: whenever the DUT accepts a read, the next data_out is scored.
  always @(posedge clock) begin
    if (resetn && !soft_reset && read_enb && !empty) begin
      #1;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected actual=%0h required=none", data_out);
      end else begin
        check("rd_data", data_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn     = 1'b0;
    soft_reset = 1'b0;
    write_enb  = 1'b1;
    read_enb   = 1'b0;
    lfd_state  = 1'b0;
    data_in    = 8'h77;
    repeat (2) @(posedge clock);
    #1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_dout", data_out, 8'h00);
    resetn    = 1'b1;
    write_enb = 1'b0;
    idle();
    idle();

    // single packet: header len 3 addr 1, three payload bytes, parity
    wr(1'b1, 8'h0D);
    wr(1'b0, 8'hA1);
    wr(1'b0, 8'hA2);
    wr(1'b0, 8'hA3);
    wr(1'b0, 8'h5E);
    repeat (5) rd();
    idle();
    idle();

    // fill and overflow
    for (int i = 0; i < 17; i++) wr(1'b0, 8'(i + 8'h10));
    idle();
    repeat (16) rd();
    idle();

    // read+write while full: write dropped, full falls
    for (int i = 0; i < 16; i++) wr(1'b0, 8'(i + 8'h80));
    step(1'b1, 1'b1, 1'b0, 8'hEE, 1'b0);
    idle();
    repeat (16) rd();
    idle();

    // read+write while empty: read ignored, write lands
    step(1'b1, 1'b1, 1'b0, 8'h3C, 1'b0);
    idle();
    rd();
    idle();

    // soft reset mid-packet
    wr(1'b1, 8'h09);
    wr(1'b0, 8'hB1);
    wr(1'b0, 8'hB2);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    rd();
    idle();

    // soft reset while the packet counter is non-zero
    wr(1'b1, 8'h09);
    wr(1'b0, 8'hC1);
    wr(1'b0, 8'hC2);
    rd();
    rd();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    wr(1'b0, 8'hC7);
    rd();
    idle();

    // truncated packet: second header reloads the counter
    wr(1'b1, 8'h14);
    wr(1'b0, 8'hD1);
    wr(1'b1, 8'h04);
    wr(1'b0, 8'hD2);
    wr(1'b0, 8'hD3);
    repeat (5) rd();
    idle();
    idle();

    // pointer wrap with interleaved single writes and reads
    for (int i = 0; i < 40; i++) begin
      wr(1'b0, 8'(i + 8'h40));
      rd();
    end
    idle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), 8'($urandom),
           1'($urandom_range(0, 63) == 0));
    end
    repeat (17) rd();
    idle();
    idle();

    check("exp_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
